pattern_tx: RTL
===============

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the maximum pattern length in bits and the width of data.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port start  input  1  request to transmit one pattern; sampled each rising clk.
REQ-005 The block SHALL have port data  input  WIDTH  pattern bits, captured with start; bit len-1 is sent first.
REQ-006 The block SHALL have port len  input  4  number of data bits to send (1..WIDTH), captured with start.
REQ-007 The block SHALL have port out  output  1  serial line toward the sequence detector; registered.
REQ-008 The block SHALL have port busy  output  1  high while a pattern is in flight; registered.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking end of a pattern; registered.

Function
REQ-010 The FSM SHALL have states IDLE, SEND, PARITY (only with the macro) and GAP, in an explicit encoded state register, with default arm returning to IDLE.
REQ-011 In IDLE, out=0, busy=0 and done=0.
REQ-012 A start=1 sampled in IDLE with len>=1 SHALL capture data and len, enter SEND, and drive out=data[len-1], busy=1 in the cycle right after that edge (latency 1).
REQ-013 In SEND, each rising edge SHALL advance one bit, MSB-first from bit len-1 down to bit 0, one bit per clock, no gaps.
REQ-014 After bit 0 has been held one cycle, the FSM SHALL enter GAP (or PARITY when enabled).
REQ-015 GAP SHALL last exactly one cycle with out=0, busy=1, done=1; the following edge returns to IDLE.
REQ-016 Total busy time SHALL be len+1 cycles without parity, len+2 with parity.
REQ-017 start SHALL be ignored in SEND, PARITY and GAP; captured data/len SHALL not change mid-pattern.
REQ-018 start with len=0 SHALL be ignored; the FSM stays in IDLE and done stays 0.
REQ-019 len greater than WIDTH SHALL be clamped to WIDTH at capture.
REQ-020 A start held high continuously SHALL produce back-to-back patterns, each re-captured in IDLE, separated by GAP plus one IDLE cycle.
REQ-021 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-022 On rst=1 at a rising edge, state SHALL become IDLE, out=0, busy=0, done=0, and the shift and bit counters SHALL clear.
REQ-023 rst SHALL take priority over start in the same cycle.
REQ-024 rst during SEND/PARITY/GAP SHALL abort the pattern with no done pulse; out=0 from the next cycle.
REQ-025 After rst deasserts, the first start SHALL be accepted on the first edge it is sampled in IDLE.

Configuration
REQ-026 Macro PATTERN_TX_PARITY_EN, when defined, SHALL compile in the PARITY state: one extra cycle after bit 0 driving out = XOR of the len transmitted bits (even parity), busy=1, done=0, then GAP.
REQ-027 Without PATTERN_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and SEND goes directly to GAP.

Verification
REQ-028 Reset then start=1, data=8'b0000_1001, len=4 -> out 1,0,0,1 on cycles 1..4 after the start edge, done=1 on cycle 5, busy high cycles 1..5.
REQ-029 start=1, data=8'hFF, len=2 -> out 1,1 then GAP; busy exactly 3 cycles, one done pulse.
REQ-030 start re-asserted in cycle 2 of a len=8 pattern with different data -> ignored; all 8 bits match the first data, one done.
REQ-031 rst=1 in cycle 3 of a len=6 pattern -> out=0, busy=0 next cycle, no done; a new start after rst sends cleanly.
REQ-032 start=1 with len=0 -> busy and done stay 0; len=12 with WIDTH=8 -> exactly 8 bits sent.
REQ-033 With PATTERN_TX_PARITY_EN, data=8'b0000_1011, len=4 -> out 1,0,1,1 then parity 1, then GAP done; busy 6 cycles.

Source files
------------

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends len bits of data MSB-first, then a one-cycle GAP with a done pulse.
// Define PATTERN_TX_PARITY_EN to insert an even-parity bit between the last data bit and GAP.
module pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int SW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

`ifdef PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PARITY = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd3} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef PATTERN_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic [3:0]       len_clamped;
  logic [SW-1:0]    shift_amt;

  // Left-align the captured pattern so the bit to transmit is always at the MSB.
  always_comb begin
    if (int'(len) > WIDTH) len_clamped = 4'(WIDTH);
    else                   len_clamped = len;
    shift_amt = SW'(WIDTH) - SW'(len_clamped);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      out_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
      out_reg    <= out_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef PATTERN_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Outputs are computed for the state being entered, then registered alongside it.
  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
    out_next    = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start && (len_clamped != 4'd0)) begin
          shift_next  = data << shift_amt;
          cnt_next    = len_clamped - 4'd1;
          out_next    = shift_next[WIDTH-1];
          busy_next   = 1'b1;
`ifdef PATTERN_TX_PARITY_EN
          // Bits above len-1 were shifted out, so this is the parity of the sent bits only.
          parity_next = ^shift_next;
`endif
          state_next  = SEND;
        end
      end
      SEND: begin
        busy_next = 1'b1;
        if (cnt_reg == 4'd0) begin
`ifdef PATTERN_TX_PARITY_EN
          out_next   = parity_reg;
          state_next = PARITY;
`else
          done_next  = 1'b1;
          state_next = GAP;
`endif
        end else begin
          shift_next = shift_reg << 1;
          cnt_next   = cnt_reg - 4'd1;
          out_next   = shift_next[WIDTH-1];
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      PARITY: begin
        busy_next  = 1'b1;
        done_next  = 1'b1;
        state_next = GAP;
      end
`endif
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out  = out_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
